// File: rtl/cla_pkg.sv
// Shared definitions for the pipelined carry-lookahead adder: operation encoding
// and the stage-count / width-legality helpers used at elaboration.
package cla_pkg;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_e;

  function automatic int unsigned nblk(input int unsigned width, input int unsigned block);
    return width / block;
  endfunction

  function automatic bit width_ok(input int unsigned width, input int unsigned block);
    return (block != 0) && (width != 0) && ((width % block) == 0);
  endfunction

endpackage

// File: rtl/cla_block.sv
// Combinational BLOCK-bit carry-lookahead group: every internal carry is formed
// from prefix generate/propagate terms and the group carry-in directly.
module cla_block #(
  parameter int unsigned BLOCK = 4
) (
  input  logic [BLOCK-1:0] a,
  input  logic [BLOCK-1:0] b,
  input  logic             ci,
  output logic [BLOCK-1:0] s,
  output logic             G,
  output logic             P,
  output logic             co,
  output logic             c_msb
);

  logic [BLOCK-1:0] g;
  logic [BLOCK-1:0] p;
  logic [BLOCK-1:0] gg;
  logic [BLOCK-1:0] pp;
  logic [BLOCK:0]   c;

  always_comb begin
    g     = a & b;
    p     = a ^ b;
    gg    = '0;
    pp    = '0;
    gg[0] = g[0];
    pp[0] = p[0];
    for (int unsigned i = 1; i < BLOCK; i++) begin
      gg[i] = g[i] | (p[i] & gg[i-1]);
      pp[i] = p[i] & pp[i-1];
    end
    // c[i+1] depends only on the prefix terms and ci, not on c[i]
    c    = '0;
    c[0] = ci;
    for (int unsigned i = 0; i < BLOCK; i++) begin
      c[i+1] = gg[i] | (pp[i] & ci);
    end
  end

  assign s     = p ^ c[BLOCK-1:0];
  assign G     = gg[BLOCK-1];
  assign P     = pp[BLOCK-1];
  assign co    = c[BLOCK];
  assign c_msb = c[BLOCK-1];

endmodule

// File: rtl/cla_pipe_adder.sv
// Pipelined adder/subtractor: one BLOCK-bit lookahead group resolved per stage,
// inter-group carry registered, valid/ready stream with a single global stall.
module cla_pipe_adder
  import cla_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned BLOCK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned NBLK = nblk(WIDTH, BLOCK);

  if (!width_ok(WIDTH, BLOCK)) begin : g_width_chk
    $error("cla_pipe_adder: WIDTH (%0d) must be a non-zero multiple of BLOCK (%0d)",
           WIDTH, BLOCK);
  end

  op_e             op;
  logic            en;
  logic            accept;
  logic [WIDTH-1:0] b_eff;
  logic            c_eff;

  // Register set 0 captures the operands; set k+1 holds groups 0..k resolved.
  logic [NBLK:0]    vld_q,   vld_d;
  logic [NBLK:0]    carry_q, carry_d;
  logic [WIDTH-1:0] sum_q [NBLK+1];
  logic [WIDTH-1:0] sum_d [NBLK+1];
  logic [WIDTH-1:0] a_q   [NBLK];
  logic [WIDTH-1:0] a_d   [NBLK];
  logic [WIDTH-1:0] b_q   [NBLK];
  logic [WIDTH-1:0] b_d   [NBLK];
  logic             cmsb_q, cmsb_d;

  logic [BLOCK-1:0] blk_s [NBLK];
  logic [NBLK-1:0]  blk_g;
  logic [NBLK-1:0]  blk_p;
  logic [NBLK-1:0]  blk_co;
  logic [NBLK-1:0]  blk_cmsb;

  assign op     = op_e'(sub);
  assign b_eff  = (op == OP_SUB) ? ~b : b;
  assign c_eff  = (op == OP_SUB) ? 1'b1 : cin;

  assign out_valid = vld_q[NBLK];
  assign en        = !(out_valid && !out_ready);
  assign in_ready  = en && !rst;
  assign accept    = in_valid && in_ready;

  for (genvar k = 0; k < NBLK; k++) begin : g_stage
    cla_block #(
      .BLOCK(BLOCK)
    ) u_blk (
      .a     (a_q[k][k*BLOCK +: BLOCK]),
      .b     (b_q[k][k*BLOCK +: BLOCK]),
      .ci    (carry_q[k]),
      .s     (blk_s[k]),
      .G     (blk_g[k]),
      .P     (blk_p[k]),
      .co    (blk_co[k]),
      .c_msb (blk_cmsb[k])
    );
  end

  always_comb begin
    vld_d   = vld_q;
    carry_d = carry_q;
    sum_d   = sum_q;
    a_d     = a_q;
    b_d     = b_q;
    cmsb_d  = cmsb_q;
    if (en) begin
      vld_d[0]   = accept;
      sum_d[0]   = '0;
      a_d[0]     = a;
      b_d[0]     = b_eff;
      carry_d[0] = c_eff;
      for (int unsigned k = 0; k < NBLK; k++) begin
        vld_d[k+1]                    = vld_q[k];
        sum_d[k+1]                    = sum_q[k];
        sum_d[k+1][k*BLOCK +: BLOCK]  = blk_s[k];
        carry_d[k+1]                  = blk_co[k];
      end
      for (int unsigned k = 1; k < NBLK; k++) begin
        a_d[k] = a_q[k-1];
        b_d[k] = b_q[k-1];
      end
      cmsb_d = blk_cmsb[NBLK-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q   <= '0;
      carry_q <= '0;
      cmsb_q  <= 1'b0;
      for (int unsigned k = 0; k <= NBLK; k++) begin
        sum_q[k] <= '0;
      end
      for (int unsigned k = 0; k < NBLK; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
      end
    end else begin
      vld_q   <= vld_d;
      carry_q <= carry_d;
      cmsb_q  <= cmsb_d;
      sum_q   <= sum_d;
      a_q     <= a_d;
      b_q     <= b_d;
    end
  end

  assign sum  = sum_q[NBLK];
  assign cout = carry_q[NBLK];
  assign ovf  = cmsb_q ^ carry_q[NBLK];

  // Group G/P and the non-final carry-into-MSB taps are not needed here.
  logic unused_blk;
  assign unused_blk = ^{blk_g, blk_p, blk_cmsb};

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Self-checking bench for cla_pipe_adder (WIDTH=16, BLOCK=4): directed corner
// vectors, backpressure, mid-stream reset and randomized traffic vs. a model.
module tb_cla_pipe_adder;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        cin;
  logic        sub;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] sum;
  logic        cout;
  logic        ovf;

  int checks = 0;
  int errors = 0;

  logic [17:0] exp_q[$];
  logic [17:0] got_q[$];

  always #5 clk = ~clk;

  cla_pipe_adder #(
    .WIDTH(16),
    .BLOCK(4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf)
  );

  // Reference: {ovf, cout, sum} from plain integer arithmetic.
  function automatic logic [17:0] model(input logic [15:0] x, input logic [15:0] y,
                                         input logic ci, input logic sb);
    int          sx;
    int          sy;
    int          sres;
    int unsigned ures;
    logic        r_cout;
    logic        r_ovf;
    sx = int'($signed(x));
    sy = int'($signed(y));
    if (sb) begin
      ures   = int'(x) - int'(y);
      sres   = sx - sy;
      r_cout = (x >= y);
    end else begin
      ures   = int'(x) + int'(y) + int'(ci);
      sres   = sx + sy + int'(ci);
      r_cout = (int'(x) + int'(y) + int'(ci)) > 65535;
    end
    r_ovf = (sres > 32767) || (sres < -32768);
    return {r_ovf, r_cout, ures[15:0]};
  endfunction

  always @(negedge clk) begin
    if (!rst && in_valid && in_ready) exp_q.push_back(model(a, b, cin, sub));
    if (!rst && out_valid && out_ready) got_q.push_back({ovf, cout, sum});
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    tick();
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b expected 0", in_ready); end
    checks++;
    if ({out_valid, ovf, cout, sum} !== 19'h0) begin
      errors++;
      $display("FAIL reset_outputs: got valid=%b ovf=%b cout=%b sum=%h expected all 0", out_valid, ovf, cout, sum);
    end
    tick();
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready_2: got %b expected 0", in_ready); end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL post_reset: got in_ready=%b out_valid=%b expected 1/0", in_ready, out_valid);
    end
    tick();
  endtask

  task automatic test_directed();
    logic [15:0] va [5];
    logic [15:0] vb [5];
    logic        vc [5];
    logic        vs [5];
    logic [17:0] ve [5];
    va = '{16'hFFFF, 16'h7FFF, 16'h1234, 16'h8000, 16'h0003};
    vb = '{16'h0001, 16'h0001, 16'h4321, 16'h0001, 16'h0005};
    vc = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    vs = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    ve = '{{2'b01, 16'h0000}, {2'b10, 16'h8000}, {2'b00, 16'h5556},
           {2'b11, 16'h7FFF}, {2'b00, 16'hFFFE}};
    exp_q.delete(); got_q.delete();
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; a = va[i]; b = vb[i]; cin = vc[i]; sub = vs[i];
      tick();
    end
    in_valid = 1'b0;
    for (int n = 0; n < 20 && got_q.size() < 5; n++) tick();
    checks++;
    if (got_q.size() != 5) begin
      errors++; $display("FAIL directed_count: got %0d expected 5", got_q.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        checks++;
        if (got_q[i] !== ve[i]) begin
          errors++;
          $display("FAIL directed_%0d: got ovf/cout/sum=%h expected %h", i, got_q[i], ve[i]);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    int          issued = 0;
    int          stalls = 0;
    logic        stall;
    logic        prev_stall = 1'b0;
    logic [17:0] prev_out = '0;
    logic        acc;
    exp_q.delete(); got_q.delete();
    for (int c = 0; c < 80 && got_q.size() < 8; c++) begin
      out_ready = !(c >= 6 && c <= 10);
      in_valid  = (issued < 8);
      a = 16'(issued); b = 16'(issued * 256); cin = 1'b0; sub = 1'b0;
      @(negedge clk);
      stall = out_valid && !out_ready;
      if (stall) begin
        stalls++;
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready c=%0d: got %b expected 0", c, in_ready); end
      end
      if (prev_stall) begin
        checks++;
        if ({ovf, cout, sum} !== prev_out) begin
          errors++; $display("FAIL bp_frozen c=%0d: got %h expected %h", c, {ovf, cout, sum}, prev_out);
        end
      end
      prev_stall = stall;
      prev_out   = {ovf, cout, sum};
      acc        = in_valid && in_ready;
      @(posedge clk); #1;
      if (acc) issued++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    checks++;
    if (stalls != 5) begin errors++; $display("FAIL bp_stall_cycles: got %0d expected 5", stalls); end
    checks++;
    if (got_q.size() != 8) begin
      errors++; $display("FAIL bp_count: got %0d expected 8", got_q.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        checks++;
        if (got_q[i] !== {2'b00, 16'(i * 257)}) begin
          errors++; $display("FAIL bp_result_%0d: got %h expected %h", i, got_q[i], {2'b00, 16'(i * 257)});
        end
      end
    end
    tick(); tick();
  endtask

  task automatic test_reset_midstream();
    int          seen = 0;
    int          lat  = 0;
    logic [17:0] want;
    exp_q.delete(); got_q.delete();
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom); sub = 1'b0;
      tick();
    end
    in_valid = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid: got %b expected 0", out_valid); end
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    checks++;
    if (seen != 0 || got_q.size() != 0) begin
      errors++; $display("FAIL midrst_discard: got %0d valid cycles, %0d beats expected 0", seen, got_q.size());
    end
    @(posedge clk); #1;
    exp_q.delete();
    in_valid = 1'b1; a = 16'h9ABC; b = 16'h6543; cin = 1'b1; sub = 1'b0;
    want = model(a, b, cin, sub);
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int n = 1; n <= 10; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (out_valid) begin lat = n; break; end
    end
    checks++;
    if (lat != 4) begin errors++; $display("FAIL midrst_latency: got %0d expected 4", lat); end
    checks++;
    if ({ovf, cout, sum} !== want) begin
      errors++; $display("FAIL midrst_result: got %h expected %h", {ovf, cout, sum}, want);
    end
    tick(); tick();
  endtask

  task automatic test_random();
    exp_q.delete(); got_q.delete();
    for (int c = 0; c < 400; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 5))
        0:       a = 16'h7FFF;
        1:       a = 16'h8000;
        2:       a = 16'hFFFF;
        default: a = 16'($urandom);
      endcase
      b   = ($urandom_range(0, 4) == 0) ? 16'hFFFF : 16'($urandom);
      cin = 1'($urandom);
      sub = 1'($urandom);
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int n = 0; n < 20; n++) tick();
    checks++;
    if (got_q.size() != exp_q.size()) begin
      errors++; $display("FAIL rand_count: got %0d expected %0d", got_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if (got_q[i] !== exp_q[i]) begin
          errors++; $display("FAIL rand_beat_%0d: got %h expected %h", i, got_q[i], exp_q[i]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_midstream();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/cla_pipe_adder.md
# cla_pipe_adder

Parametrised, pipelined carry-lookahead adder/subtractor. It is the successor to the fixed 4-bit combinational CLA. Operands are split into BLOCK-bit lookahead groups, and one group is resolved per pipeline stage, with the inter-group carry registered between stages. Results are delivered on a valid/ready stream interface with backpressure, at one operation per cycle throughput, for use as the datapath adder in wider arithmetic units.

## Interface
- WIDTH, 16, operand/result width; must be a multiple of BLOCK (elaboration error otherwise)
- BLOCK, 4, lookahead group width; NBLK = WIDTH/BLOCK stages
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operand beat present
- in_ready  out  1  operand beat accepted when in_valid && in_ready
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- cin  in  1  carry-in (ADD mode only)
- sub  in  1  0 = A+B+cin, 1 = A−B (B inverted, carry-in forced 1, cin ignored)
- out_valid  out  1  result beat present
- out_ready  in  1  consumer accepts when out_valid && out_ready
- sum  out  WIDTH  result
- cout  out  1  carry out of MSB (in SUB mode, 1 = no borrow)
- ovf  out  1  signed two's-complement overflow

## Operation
- Effective B is b ^ {WIDTH{sub}}. Effective carry-in is sub ? 1 : cin.
- Stage k (k = 0..NBLK−1) computes group k (bits k·BLOCK .. k·BLOCK+BLOCK−1):
  - group generate/propagate;
  - BLOCK-bit CLA sum using the registered carry from stage k−1 (stage 0 uses the effective carry-in).
- Each stage registers:
  - valid bit;
  - sum bits produced so far;
  - unconsumed operand bits of A and effective B;
  - carry into the next group;
  - carry into the MSB (needed for ovf).
- Final stage register drives sum, cout, and ovf = carry_into_msb ^ cout.
- Global enable en = !(out_valid && !out_ready). When en = 0, every stage register holds, including bubbles (no bubble collapse).
- in_ready = en && !rst.
- Results emerge strictly in acceptance order. No beat is dropped or duplicated.

## Timing
- Latency: a beat accepted at edge t drives out_valid high after edge t+NBLK, given no stall. Default is 4 cycles.
- Throughput: one beat per cycle while out_ready = 1.
- Stall: out_valid && !out_ready freezes the whole pipe and in_ready drops in the same cycle (combinational from out_ready). sum, cout and ovf stay stable while stalled.
- Reset: at the edge where rst = 1, all stage valid bits, sum, cout and ovf are cleared to 0. out_valid is 0 on the following cycle. in_ready is 0 while rst is high.
- Reset mid-operation: in-flight beats are discarded and never appear on the output.
- Simultaneous accept and emit during a stall release: when out_ready rises, the head beat leaves and a new beat enters on the same edge.
- Wrap-around: arithmetic is modulo 2^WIDTH. cout and ovf report the overflow; there is no saturation.

## Structure
- Shared package cla_pkg holds:
  - localparam helper function nblk(WIDTH, BLOCK);
  - the op-mode encoding (OP_ADD = 0, OP_SUB = 1);
  - the width check, implemented as a generate-time $error.
- One sub-module, cla_block: combinational BLOCK-bit lookahead with inputs a, b, ci and outputs s, G, P, co, c_msb. It is instantiated once per stage via generate.
- Top level holds the stage register arrays, the enable/handshake logic and the output registers. Expected size is about 200 lines.

## Test plan
Defaults: WIDTH = 16, BLOCK = 4.
- Reset: hold rst for 2 cycles → sum = 0x0000, cout = 0, ovf = 0, out_valid = 0, in_ready = 0 during rst and 1 after.
- ADD carry ripple across all groups: a = 0xFFFF, b = 0x0001, cin = 0 → 4 cycles later sum = 0x0000, cout = 1, ovf = 0.
- Signed overflow in ADD: a = 0x7FFF, b = 0x0001 → sum = 0x8000, cout = 0, ovf = 1. With cin = 1, a = 0x1234, b = 0x4321 → sum = 0x5556.
- SUB mode: sub = 1, a = 0x8000, b = 0x0001, cin = 1 (ignored) → sum = 0x7FFF, cout = 1, ovf = 1. a = 0x0003, b = 0x0005 → sum = 0xFFFE, cout = 0, ovf = 0.
- Backpressure: stream 8 back-to-back beats a = i, b = 0x0100·i. Hold out_ready = 0 for cycles 6–10 → in_ready low while stalled, output frozen, all 8 results a + b appear in order with none lost or duplicated.
- Reset mid-stream: with 3 beats in flight, pulse rst for 1 cycle → out_valid = 0 from the next cycle, none of the 3 results ever emerge, and a new beat issued afterwards returns after 4 cycles.
